// File: rtl/div_issue_queue_pkg.sv
// div_pkg: shared widths, operand record and issue FSM states for the divider issue queue
package div_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W = 4;
  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0] divisor;
  } div_op_t;
  typedef enum logic [1:0] {IDLE, START, WAIT} issue_state_t;
endpackage

// File: rtl/div_issue_queue_if.sv
// div_issue_queue_if: producer valid/ready, divider launch/done, status (busy, level) and optional DIV_ZERO_FILTER_EN error ports; slave = queue, master = environment
interface div_issue_queue_if import div_pkg::*; #(parameter int DEPTH = 4);
  logic in_valid, in_ready, div_start, div_done, busy;
  logic [DIVIDEND_W-1:0] in_dividend, div_a;
  logic [DIVISOR_W-1:0] in_divisor, div_b;
  logic [$clog2(DEPTH+1)-1:0] level;
`ifdef DIV_ZERO_FILTER_EN
  logic err_div0;
  logic [7:0] err_count;
`endif
  modport slave (
    input in_valid, in_dividend, in_divisor, div_done,
    output in_ready, div_a, div_b, div_start, busy, level
`ifdef DIV_ZERO_FILTER_EN
    , output err_div0, err_count
`endif
  );
  modport master (
    output in_valid, in_dividend, in_divisor, div_done,
    input in_ready, div_a, div_b, div_start, busy, level
`ifdef DIV_ZERO_FILTER_EN
    , input err_div0, err_count
`endif
  );
endinterface

// File: rtl/div_issue_queue_fifo.sv
// div_op_fifo: circular operand buffer (clk, rst_n, push/wdata, pop/rdata head, full, level) with wrapping pointers and occupancy counter
module div_op_fifo import div_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = div_op_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  assign rdata = mem[rp];
  assign full = level == LW'(DEPTH);
endmodule

// File: rtl/div_issue_queue.sv
// div_issue_queue: stages operand pairs in a FIFO and issues them one at a time to the divider; ports clk, rst_n, io (div_issue_queue_if.slave); DIV_ZERO_FILTER_EN drops divisor-0 entries and adds err_div0/err_count
module div_issue_queue import div_pkg::*; #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst_n,
  div_issue_queue_if.slave io
);
  div_op_t in_op, head;
  logic full, pop, zero;
  issue_state_t state, nxt;
  assign in_op = '{dividend: io.in_dividend, divisor: io.in_divisor};
  div_op_fifo #(.DEPTH(DEPTH), .T(div_op_t)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(io.in_valid && io.in_ready),
    .pop(pop),
    .wdata(in_op),
    .rdata(head),
    .full(full),
    .level(io.level)
  );
  assign io.in_ready = !full;
`ifdef DIV_ZERO_FILTER_EN
  assign zero = head.divisor == '0;
`else
  assign zero = 1'b0;
`endif
  assign pop = io.level != '0 && (state == IDLE || (state == WAIT && io.div_done));
  assign nxt = pop ? (zero ? IDLE : START)
             : state == START ? WAIT
             : state == WAIT && io.div_done ? IDLE
             : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      io.div_start <= 1'b0;
      io.busy <= 1'b0;
      io.div_a <= '0;
      io.div_b <= '0;
    end else begin
      state <= nxt;
      io.div_start <= nxt == START;
      io.busy <= nxt != IDLE;
      if (pop && !zero) begin
        io.div_a <= head.dividend;
        io.div_b <= head.divisor;
      end
    end
`ifdef DIV_ZERO_FILTER_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      io.err_div0 <= 1'b0;
      io.err_count <= '0;
    end else begin
      io.err_div0 <= pop && zero;
      if (pop && zero && io.err_count != 8'hff) io.err_count <= io.err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_div_issue_queue.sv
// tb_div_issue_queue: vector table, reset/filter sequences and randomized run against a queue-based model
module tb_div_issue_queue;
  import div_pkg::*;
  localparam int DEPTH = 4;
  logic clk, rst_n;
  int n_cmp, n_bad;
  div_issue_queue_if #(.DEPTH(DEPTH)) io ();
  div_issue_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic v;
    logic [7:0] a;
    logic [3:0] b;
    logic d;
    logic rdy;
    int lvl;
    logic st;
    logic bz;
    logic [7:0] ea;
    logic [3:0] eb;
  } vec_t;
  vec_t tbl[22];
  logic [11:0] m_q[$];
  logic m_run, m_start, m_err;
  logic [7:0] m_a, m_cnt;
  logic [3:0] m_b;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic m_reset();
    m_q.delete();
    m_run = 0;
    m_start = 0;
    m_err = 0;
    m_a = 0;
    m_b = 0;
    m_cnt = 0;
  endtask
  task automatic m_step();
    logic acc, issue, ending;
    logic [11:0] op;
    acc = io.in_valid && m_q.size() < DEPTH;
    ending = m_run && !m_start && io.div_done;
    issue = m_q.size() != 0 && (!m_run || ending);
    m_err = 0;
    if (issue) begin
      op = m_q.pop_front();
`ifdef DIV_ZERO_FILTER_EN
      if (op[3:0] == 4'd0) begin
        m_err = 1;
        if (m_cnt != 8'hff) m_cnt++;
        m_run = 0;
        m_start = 0;
      end else
`endif
      begin
        m_a = op[11:4];
        m_b = op[3:0];
        m_run = 1;
        m_start = 1;
      end
    end else begin
      m_start = 0;
      if (ending) m_run = 0;
    end
    if (acc) m_q.push_back({io.in_dividend, io.in_divisor});
  endtask
  task automatic drv(input logic v, input logic [7:0] a, input logic [3:0] b, input logic d);
    io.in_valid = v;
    io.in_dividend = a;
    io.in_divisor = b;
    io.div_done = d;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    m_step();
  endtask
  task automatic do_reset();
    rst_n = 0;
    drv(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
  endtask
  initial begin
    int starts;
    n_cmp = 0;
    n_bad = 0;
    tbl[0]  = '{1, 100, 7, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 0, 1, 1, 100, 7};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 1, 100, 7};
    tbl[3]  = '{0, 0, 0, 1, 1, 0, 0, 0, 100, 7};
    tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 0, 100, 7};
    tbl[5]  = '{1, 1, 1, 0, 1, 1, 0, 0, 100, 7};
    tbl[6]  = '{1, 2, 2, 0, 1, 1, 1, 1, 1, 1};
    tbl[7]  = '{1, 3, 3, 0, 1, 2, 0, 1, 1, 1};
    tbl[8]  = '{1, 4, 4, 0, 1, 3, 0, 1, 1, 1};
    tbl[9]  = '{1, 5, 5, 0, 0, 4, 0, 1, 1, 1};
    tbl[10] = '{1, 6, 6, 0, 0, 4, 0, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 1, 3, 1, 1, 2, 2};
    tbl[12] = '{0, 0, 0, 1, 1, 3, 0, 1, 2, 2};
    tbl[13] = '{0, 0, 0, 1, 1, 2, 1, 1, 3, 3};
    tbl[14] = '{0, 0, 0, 0, 1, 2, 0, 1, 3, 3};
    tbl[15] = '{1, 8, 8, 1, 1, 2, 1, 1, 4, 4};
    tbl[16] = '{0, 0, 0, 0, 1, 2, 0, 1, 4, 4};
    tbl[17] = '{0, 0, 0, 1, 1, 1, 1, 1, 5, 5};
    tbl[18] = '{0, 0, 0, 0, 1, 1, 0, 1, 5, 5};
    tbl[19] = '{0, 0, 0, 1, 1, 0, 1, 1, 8, 8};
    tbl[20] = '{0, 0, 0, 0, 1, 0, 0, 1, 8, 8};
    tbl[21] = '{0, 0, 0, 1, 1, 0, 0, 0, 8, 8};
    rst_n = 0;
    drv(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", io.in_ready, 1);
    chk("reset level", io.level, 0);
    chk("reset div_start", io.div_start, 0);
    chk("reset busy", io.busy, 0);
    chk("reset div_a", io.div_a, 0);
    chk("reset div_b", io.div_b, 0);
    rst_n = 1;
    m_reset();
    for (int i = 0; i < 22; i++) begin
      drv(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].d);
      cyc();
      chk($sformatf("vec%0d in_ready", i), io.in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d level", i), io.level, tbl[i].lvl);
      chk($sformatf("vec%0d div_start", i), io.div_start, tbl[i].st);
      chk($sformatf("vec%0d busy", i), io.busy, tbl[i].bz);
      chk($sformatf("vec%0d div_a", i), io.div_a, tbl[i].ea);
      chk($sformatf("vec%0d div_b", i), io.div_b, tbl[i].eb);
    end
    for (int i = 0; i < 4; i++) begin
      drv(1, 8'(9 + i), 4'(1 + i), 0);
      cyc();
    end
    drv(0, 0, 0, 0);
    cyc();
    chk("pre-reset busy", io.busy, 1);
    chk("pre-reset level", io.level, 3);
    rst_n = 0;
    #1;
    chk("async reset level", io.level, 0);
    chk("async reset busy", io.busy, 0);
    chk("async reset div_start", io.div_start, 0);
    chk("async reset in_ready", io.in_ready, 1);
    chk("async reset div_a", io.div_a, 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    drv(0, 0, 0, 1);
    cyc();
    chk("stray done start", io.div_start, 0);
    chk("stray done busy", io.busy, 0);
    drv(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("post-stray start", io.div_start, 0);
      chk("post-stray busy", io.busy, 0);
    end
`ifdef DIV_ZERO_FILTER_EN
    do_reset();
    drv(1, 50, 0, 0);
    cyc();
    drv(1, 50, 5, 0);
    cyc();
    chk("div0 err pulse", io.err_div0, 1);
    chk("div0 err_count", io.err_count, 1);
    chk("div0 no start", io.div_start, 0);
    drv(0, 0, 0, 0);
    cyc();
    chk("div0 next start", io.div_start, 1);
    chk("div0 next b", io.div_b, 5);
    chk("div0 err cleared", io.err_div0, 0);
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      starts += int'(io.div_start);
    end
    chk("div0 extra starts", starts, 0);
`endif
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 9) < 6, 8'($urandom), 4'($urandom), $urandom_range(0, 9) < 3);
      cyc();
      chk("rnd in_ready", io.in_ready, int'(m_q.size() < DEPTH));
      chk("rnd level", io.level, m_q.size());
      chk("rnd div_start", io.div_start, m_start);
      chk("rnd busy", io.busy, m_run);
      chk("rnd div_a", io.div_a, m_a);
      chk("rnd div_b", io.div_b, m_b);
`ifdef DIV_ZERO_FILTER_EN
      chk("rnd err_div0", io.err_div0, m_err);
      chk("rnd err_count", io.err_count, m_cnt);
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
